// File: rtl/framebuffer_rect_engine_if.sv
// Bus between drawing/scan-out logic and framebuffer_rect_engine.
// master = drawing/scan-out side, slave = framebuffer.
interface framebuffer_rect_engine_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 15,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7
);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] q;
  logic                  we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  fill_start;
  logic [X_WIDTH-1:0]    fill_x0;
  logic [X_WIDTH-1:0]    fill_x1;
  logic [Y_WIDTH-1:0]    fill_y0;
  logic [Y_WIDTH-1:0]    fill_y1;
  logic [DATA_WIDTH-1:0] fill_color;
  logic                  fill_busy;
  logic                  fill_done;

  modport master (
    output read_addr, we, write_addr, data,
    output fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    input  q, fill_busy, fill_done
  );

  modport slave (
    input  read_addr, we, write_addr, data,
    input  fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color,
    output q, fill_busy, fill_done
  );
endinterface

// File: rtl/framebuffer_rect_engine.sv
// Parametrised framebuffer with a raster rectangle-fill engine.
// Define FB_CLEAR_ON_RESET_EN to clear memory to CLEAR_VALUE after reset.
module framebuffer_rect_engine #(
  parameter int DATA_WIDTH  = 1,
  parameter int H_PIXELS    = 160,
  parameter int V_PIXELS    = 120,
  parameter int ADDR_WIDTH  = 15,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int CLEAR_VALUE = 0
) (
  input logic clock,
  input logic reset_n,
  framebuffer_rect_engine_if.slave fb
);
  localparam int NPIX = H_PIXELS * V_PIXELS;
  localparam int IDXW = $clog2(NPIX);
  localparam logic [ADDR_WIDTH:0]   NPIX_W = (ADDR_WIDTH+1)'(NPIX);
  localparam logic [X_WIDTH-1:0]    X_MAX  = X_WIDTH'(H_PIXELS - 1);
  localparam logic [Y_WIDTH-1:0]    Y_MAX  = Y_WIDTH'(V_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_PIXELS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic [1:0] S_CLEAR = 2'd3;
  localparam logic [1:0] S_RESET = S_CLEAR;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NPIX - 1);
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
`else
  localparam logic [1:0] S_RESET = S_IDLE;
`endif

  logic [1:0]            state_q, state_d;
  logic [X_WIDTH-1:0]    x_q, x_d, x0_q, x0_d, x1c_q, x1c_d;
  logic [Y_WIDTH-1:0]    y_q, y_d, y1c_q, y1c_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic                  busy_q, busy_d, done_q;
  logic [DATA_WIDTH-1:0] q_q;

  logic [X_WIDTH-1:0]    x1c;
  logic [Y_WIDTH-1:0]    y1c;
  logic                  empty;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem [NPIX];

  assign x1c   = (fb.fill_x1 > X_MAX) ? X_MAX : fb.fill_x1;
  assign y1c   = (fb.fill_y1 > Y_MAX) ? Y_MAX : fb.fill_y1;
  assign empty = (fb.fill_x0 > x1c) || (fb.fill_y0 > y1c);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x0_d      = x0_q;
    x1c_d     = x1c_q;
    y1c_d     = y1c_q;
    row_d     = row_q;
    color_d   = color_q;
    mem_we    = 1'b0;
    mem_waddr = row_q + ADDR_WIDTH'(x_q);
    mem_wdata = DATA_WIDTH'(CLEAR_VALUE);
`ifdef FB_CLEAR_ON_RESET_EN
    clr_d     = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Direct writes only land in IDLE so they never collide with engine writes.
        if (fb.we && !busy_q && ({1'b0, fb.write_addr} < NPIX_W)) begin
          mem_we    = 1'b1;
          mem_waddr = fb.write_addr;
          mem_wdata = fb.data;
        end
        if (fb.fill_start) begin
          x0_d    = fb.fill_x0;
          x1c_d   = x1c;
          y1c_d   = y1c;
          color_d = fb.fill_color;
          x_d     = fb.fill_x0;
          y_d     = fb.fill_y0;
          row_d   = ADDR_WIDTH'(int'(fb.fill_y0) * H_PIXELS);
          state_d = empty ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_wdata = color_q;
        if (x_q == x1c_q) begin
          if (y_q == y1c_q) begin
            state_d = S_DONE;
          end else begin
            x_d   = x0_q;
            y_d   = y_q + 1'b1;
            row_d = row_q + H_STEP;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef FB_CLEAR_ON_RESET_EN
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        if (clr_q == LAST_A) state_d = S_IDLE;
        else                 clr_d   = clr_q + 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // busy/done trail the state by one edge, so busy covers exactly the written edges.
`ifdef FB_CLEAR_ON_RESET_EN
  assign busy_d = (state_q == S_FILL) || (state_q == S_CLEAR);
`else
  assign busy_d = (state_q == S_FILL);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1c_q   <= '0;
      y1c_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
`ifdef FB_CLEAR_ON_RESET_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      x1c_q   <= x1c_d;
      y1c_q   <= y1c_d;
      row_q   <= row_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      done_q  <= (state_q == S_DONE);
      q_q     <= ({1'b0, fb.read_addr} < NPIX_W) ? mem[fb.read_addr[IDXW-1:0]] : '0;
`ifdef FB_CLEAR_ON_RESET_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr[IDXW-1:0]] <= mem_wdata;
  end

  assign fb.q         = q_q;
  assign fb.fill_busy = busy_q;
  assign fb.fill_done = done_q;
endmodule
